spi_reg_bank: RTL and testbench

Register bank that consumes the byte stream produced by the PICO front end. It crosses `msg_flag`, `write_data` and `mux_control_signal` from the sclk domain into the internal clock domain. It decodes each completed byte as either an address byte or a data byte, and commits data bytes into an array of 8-bit configuration registers. It also returns the currently addressed register to the POCI path.

---
 rtl/spi_reg_bank.sv | 124 ++++++++++++
 tb/tb_spi_reg_bank.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_reg_bank.sv
// Register bank fed by the PICO byte stream: synchronizes the byte flag, decodes
// address/data bytes and commits data bytes into NUM_REGS 8-bit registers.
module spi_reg_bank #(
    parameter int unsigned NUM_REGS     = 16,
    parameter int unsigned IDLE_TIMEOUT = 32
) (
    input  logic                    iclk,
    input  logic                    rst,
    input  logic                    msg_flag,
    input  logic [7:0]              write_data,
    input  logic [7:0]              mux_control_signal,
    output logic [NUM_REGS*8-1:0]   regs_flat,
    output logic [7:0]              rd_data,
    output logic                    wr_strobe,
    output logic [7:0]              wr_addr,
    output logic                    busy,
    output logic                    err_oor
);

    localparam logic [7:0] LP_NUM_REGS = 8'(NUM_REGS);
    localparam logic [7:0] LP_TIMEOUT  = 8'(IDLE_TIMEOUT);

    logic                  r_f1, r_f2, r_f3;
    logic [7:0]            r_cap_data;
    logic [7:0]            r_cap_ptr;
    logic                  r_evt_d;
    logic [7:0]            r_last_ptr;
    logic [7:0]            r_timer;
    logic [NUM_REGS*8-1:0] r_regs;
    logic [7:0]            r_rd_data;
    logic                  r_wr_strobe;
    logic [7:0]            r_wr_addr;
    logic                  r_busy;
    logic                  r_err_oor;

    logic                  w_event;
    logic [7:0]            w_rd_sel;

    // Flops reset high because PICO idles msg_flag high; avoids a fake edge after reset.
    always_ff @(posedge iclk) begin
        if (rst) begin
            r_f1 <= 1'b1;
            r_f2 <= 1'b1;
            r_f3 <= 1'b1;
        end else begin
            r_f1 <= msg_flag;
            r_f2 <= r_f1;
            r_f3 <= r_f2;
        end
    end

    assign w_event = r_f2 & ~r_f3;

    always_comb begin
        w_rd_sel = 8'd0;
        for (int unsigned k = 1; k <= NUM_REGS; k++) begin
            if (r_cap_ptr == 8'(k)) begin
                w_rd_sel = r_regs[8*k-1 -: 8];
            end
        end
    end

    always_ff @(posedge iclk) begin
        if (rst) begin
            r_cap_data  <= 8'd0;
            r_cap_ptr   <= 8'd0;
            r_evt_d     <= 1'b0;
            r_last_ptr  <= 8'd0;
            r_timer     <= 8'd0;
            r_regs      <= '0;
            r_rd_data   <= 8'd0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= 8'd0;
            r_busy      <= 1'b0;
            r_err_oor   <= 1'b0;
        end else begin
            r_evt_d     <= w_event;
            r_wr_strobe <= 1'b0;
            r_rd_data   <= w_rd_sel;

            // An event in the expiry cycle wins: timer restarts, last_ptr kept for decode.
            if (w_event) begin
                r_cap_data <= write_data;
                r_cap_ptr  <= mux_control_signal;
                r_timer    <= 8'd0;
                r_busy     <= 1'b1;
                if (r_last_ptr != 8'd0) begin
                    r_wr_strobe <= 1'b1;
                    r_wr_addr   <= r_last_ptr;
                    if (r_last_ptr > LP_NUM_REGS) begin
                        r_err_oor <= 1'b1;
                    end
                end
            end else if (r_timer != LP_TIMEOUT) begin
                r_timer <= r_timer + 8'd1;
                if (r_timer == LP_TIMEOUT - 8'd1) begin
                    r_last_ptr <= 8'd0;
                    r_busy     <= 1'b0;
                end
            end

            if (r_evt_d) begin
                r_last_ptr <= r_cap_ptr;
            end

            // Commit on the edge ending the strobe cycle; out-of-range targets match no register.
            if (r_wr_strobe) begin
                for (int unsigned k = 1; k <= NUM_REGS; k++) begin
                    if (r_wr_addr == 8'(k)) begin
                        r_regs[8*k-1 -: 8] <= r_cap_data;
                    end
                end
            end
        end
    end

    assign regs_flat = r_regs;
    assign rd_data   = r_rd_data;
    assign wr_strobe = r_wr_strobe;
    assign wr_addr   = r_wr_addr;
    assign busy      = r_busy;
    assign err_oor   = r_err_oor;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank: directed scenarios then random transactions
// compared against a byte-level reference model.
module tb_spi_reg_bank;

    localparam int unsigned N  = 16;
    localparam int unsigned T  = 32;
    localparam int unsigned FW = N*8;

    logic          iclk = 1'b0;
    logic          rst;
    logic          msg_flag;
    logic [7:0]    write_data;
    logic [7:0]    mux_control_signal;
    logic [FW-1:0] regs_flat;
    logic [7:0]    rd_data;
    logic          wr_strobe;
    logic [7:0]    wr_addr;
    logic          busy;
    logic          err_oor;

    spi_reg_bank #(.NUM_REGS(N), .IDLE_TIMEOUT(T)) dut (
        .iclk               (iclk),
        .rst                (rst),
        .msg_flag           (msg_flag),
        .write_data         (write_data),
        .mux_control_signal (mux_control_signal),
        .regs_flat          (regs_flat),
        .rd_data            (rd_data),
        .wr_strobe          (wr_strobe),
        .wr_addr            (wr_addr),
        .busy               (busy),
        .err_oor            (err_oor)
    );

    always #5 iclk = ~iclk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [7:0] m_regs [1:N];
    int         m_last;
    int         m_cap;
    int         m_wr_addr;
    int         m_strobes;
    bit         m_err;
    bit         m_busy;
    int         pico_ptr;
    int         dut_strobes = 0;
    logic [7:0] byte_q [$];

    always @(negedge iclk) begin
        if (wr_strobe) dut_strobes++;
    end

    task automatic check(input string tag, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] m_flat();
        logic [FW-1:0] f;
        f = '0;
        for (int k = 1; k <= int'(N); k++) f[8*k-1 -: 8] = m_regs[k];
        return f;
    endfunction

    function automatic logic [7:0] m_rd();
        if (m_cap >= 1 && m_cap <= int'(N)) return m_regs[m_cap];
        return 8'd0;
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".regs"},    regs_flat,        m_flat());
        check({tag, ".rd_data"}, FW'(rd_data),     FW'(m_rd()));
        check({tag, ".wr_addr"}, FW'(wr_addr),     FW'(m_wr_addr));
        check({tag, ".err_oor"}, FW'(err_oor),     FW'(m_err));
        check({tag, ".busy"},    FW'(busy),        FW'(m_busy));
        check({tag, ".strobes"}, FW'(dut_strobes), FW'(m_strobes));
    endtask

    task automatic model_clear();
        for (int k = 1; k <= int'(N); k++) m_regs[k] = 8'd0;
        m_last    = 0;
        m_cap     = 0;
        m_wr_addr = 0;
        m_err     = 1'b0;
        m_busy    = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input string tag);
        int l;
        l = $urandom_range(2, 6);
        @(negedge iclk) msg_flag = 1'b0;
        repeat (l) @(negedge iclk);
        if (pico_ptr == 0) pico_ptr = int'(b);
        else pico_ptr = (pico_ptr + 1) % 256;
        write_data         = b;
        mux_control_signal = 8'(pico_ptr);
        msg_flag           = 1'b1;
        // Byte meaning: no pending pointer -> address; otherwise data to that pointer.
        if (m_last == 0) begin
            m_last = pico_ptr;
        end else begin
            m_strobes++;
            m_wr_addr = m_last;
            if (m_last <= int'(N)) m_regs[m_last] = b;
            else m_err = 1'b1;
            m_last = pico_ptr;
        end
        m_cap  = pico_ptr;
        m_busy = 1'b1;
        repeat (8) @(negedge iclk);
        check_all(tag);
    endtask

    task automatic run_q(input string tag);
        pico_ptr = 0;
        foreach (byte_q[i]) send_byte(byte_q[i], tag);
    endtask

    task automatic idle_out(input string tag);
        repeat (T - 12) @(negedge iclk);
        check({tag, ".busy_hold"}, FW'(busy), FW'(1'b1));
        repeat (16) @(negedge iclk);
        m_last = 0;
        m_busy = 1'b0;
        check_all({tag, ".idle"});
    endtask

    task automatic do_reset(input string tag);
        @(negedge iclk) rst = 1'b1;
        repeat (3) @(negedge iclk);
        rst = 1'b0;
        model_clear();
        @(negedge iclk);
        check_all(tag);
    endtask

    initial begin
        rst                = 1'b1;
        msg_flag           = 1'b1;
        write_data         = 8'd0;
        mux_control_signal = 8'd0;
        m_strobes          = 0;
        pico_ptr           = 0;
        model_clear();
        repeat (3) @(negedge iclk);
        rst = 1'b0;
        @(negedge iclk);
        check_all("reset");

        byte_q = '{8'h03, 8'hA5};
        run_q("basic");
        idle_out("basic");

        byte_q = '{8'h02, 8'h11, 8'h22, 8'h33};
        run_q("burst");
        idle_out("burst");

        byte_q = '{8'h10, 8'h5A, 8'h6B};
        run_q("oor");
        idle_out("oor");

        byte_q = '{8'h05, 8'h77};
        run_q("tmo_a");
        idle_out("tmo");
        byte_q = '{8'h06, 8'h88};
        run_q("tmo_b");
        idle_out("tmo_b");

        byte_q = '{8'h00, 8'h00, 8'h04, 8'h99};
        run_q("addr0");
        idle_out("addr0");

        // Reset with a byte half-received and msg_flag back high before release.
        byte_q = '{8'h02, 8'h11};
        run_q("rst_mid");
        @(negedge iclk) msg_flag = 1'b0;
        repeat (2) @(negedge iclk);
        rst = 1'b1;
        repeat (2) @(negedge iclk);
        msg_flag = 1'b1;
        repeat (2) @(negedge iclk);
        rst = 1'b0;
        model_clear();
        @(negedge iclk);
        check_all("rst_mid.zero");
        repeat (6) @(negedge iclk);
        check_all("rst_mid.quiet");
        byte_q = '{8'h07, 8'h42};
        run_q("rst_after");
        idle_out("rst_after");

        for (int t = 0; t < 30; t++) begin
            int sel;
            int nd;
            logic [7:0] a;
            sel = $urandom_range(0, 9);
            if (sel == 0)      a = 8'h00;
            else if (sel == 1) a = 8'($urandom_range(17, 255));
            else if (sel == 2) a = 8'($urandom_range(250, 255));
            else               a = 8'($urandom_range(1, N));
            byte_q = '{a};
            nd = $urandom_range(1, 4);
            for (int d = 0; d < nd; d++) byte_q.push_back(8'($urandom_range(0, 255)));
            run_q("rand");
            idle_out("rand");
        end

        do_reset("final_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
